// File: rtl/mmio_pkg.sv
// Shared definitions for memory-mapped bus devices.
// Register offsets, CTRL bit positions, timer modes and device slots.
package mmio_pkg;

   localparam logic [3:0] CTRL_OFS   = 4'h0;
   localparam logic [3:0] PRESET_OFS = 4'h4;
   localparam logic [3:0] COUNT_OFS  = 4'h8;

   localparam int CTRL_EN = 0;
   localparam int CTRL_IM = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      IDLE,
      CNT,
      INT
   } tmr_state_e;

   localparam logic [31:0] DEV0_BASE = 32'h0000_7f00;
   localparam logic [31:0] DEV1_BASE = 32'h0000_7f10;
   localparam logic [31:0] DEV2_BASE = 32'h0000_7f20;

endpackage

// File: rtl/mmio_byte_merge.sv
// Byte-lane write merge: lanes with byteen set take wdata,
// the others keep the old word.
module mmio_byte_merge (
   input  logic [31:0] old_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  byteen_i,
   output logic [31:0] merged_o
);

   always_comb begin
      merged_o = old_i;
      for (int i = 0; i < 4; i++) begin
         if (byteen_i[i]) begin
            merged_o[8*i +: 8] = wdata_i[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes
// and a maskable interrupt line.
module mmio_timer
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE = 32'h0000_7f00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        flag_q, flag_d;
   tmr_state_e  state_q, state_d;

   logic [31:0] ofs;
   logic        hit;
   logic        wr_ctrl;
   logic        wr_preset;
   logic        reload;
   logic [3:0]  ctrl_wr;
   logic [31:0] preset_wr;

   assign ofs       = addr - BASE;
   assign hit       = ofs < 32'd12;
   assign wr_ctrl   = hit && (|byteen) && (ofs[3:2] == CTRL_OFS[3:2]);
   assign wr_preset = hit && (|byteen) && (ofs[3:2] == PRESET_OFS[3:2]);
   assign reload    = ctrl_q[2:1] == MODE_RELOAD;

   // CTRL only has live bits in lane 0
   assign ctrl_wr = byteen[0] ? wdata[3:0] : ctrl_q;

   mmio_byte_merge u_preset_merge (
      .old_i    (preset_q),
      .wdata_i  (wdata),
      .byteen_i (byteen),
      .merged_o (preset_wr)
   );

   always_comb begin
      rdata = '0;
      if (hit) begin
         case (ofs[3:2])
            CTRL_OFS[3:2]:   rdata = {28'b0, ctrl_q};
            PRESET_OFS[3:2]: rdata = preset_q;
            COUNT_OFS[3:2]:  rdata = count_q;
            default:         rdata = '0;
         endcase
      end
   end

   assign irq = ctrl_q[CTRL_IM] & flag_q;

   always_comb begin
      ctrl_d   = ctrl_q;
      preset_d = preset_q;
      count_d  = count_q;
      flag_d   = flag_q;
      state_d  = state_q;
      unique case (state_q)
         IDLE: begin
            if (ctrl_q[CTRL_EN]) begin
               count_d = preset_q;
               state_d = CNT;
            end
         end
         CNT: begin
            if (!ctrl_q[CTRL_EN]) begin
               state_d = IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = '0;
               flag_d  = 1'b1;
               state_d = INT;
            end
         end
         INT: begin
            state_d = IDLE;
            if (reload) begin
               flag_d = 1'b0;
            end else begin
               ctrl_d[CTRL_EN] = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // a CTRL write acknowledges and restarts, overriding the FSM
      if (wr_ctrl) begin
         ctrl_d  = ctrl_wr;
         flag_d  = 1'b0;
         state_d = IDLE;
      end
      if (wr_preset) begin
         preset_d = preset_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_q   <= '0;
         preset_q <= '0;
         count_q  <= '0;
         flag_q   <= 1'b0;
         state_q  <= IDLE;
      end else begin
         ctrl_q   <= ctrl_d;
         preset_q <= preset_d;
         count_q  <= count_d;
         flag_q   <= flag_d;
         state_q  <= state_d;
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed and random checks of mmio_timer against a cycle-level
// behavioural model of the register map and countdown rules.
module tb_mmio_timer;

   localparam logic [31:0] B  = 32'h0000_7f00;
   localparam logic [31:0] B2 = 32'h0000_7f10;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata, rdata2;
   logic        irq, irq2;

   always #5 clk = ~clk;

   mmio_timer #(.BASE(B)) dut (
      .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
      .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   mmio_timer #(.BASE(B2)) dut2 (
      .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
      .wdata(wdata), .rdata(rdata2), .irq(irq2)
   );

   int checks = 0;
   int passed = 0;
   int pulses;

   // model: registers plus a phase (0 stopped/loading, 1 counting, 2 just fired)
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset, m_count;
   bit          m_flag;
   int          m_phase;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] merge(logic [31:0] old,
                                         logic [31:0] wd, logic [3:0] be);
      logic [31:0] r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(logic [31:0] a);
      logic [31:0] off = a - B;
      if (off >= 32'd12) return 32'h0;
      if (off < 4) return {28'h0, m_ctrl};
      if (off < 8) return m_preset;
      return m_count;
   endfunction

   function automatic logic [31:0] m_irq();
      return {31'h0, m_ctrl[3] & m_flag};
   endfunction

   task automatic m_reset();
      m_ctrl = 0; m_preset = 0; m_count = 0; m_flag = 0; m_phase = 0;
   endtask

   task automatic m_edge(logic [31:0] a, logic [3:0] be, logic [31:0] wd);
      logic [31:0] off = a - B;
      logic [3:0]  nc = m_ctrl;
      logic [31:0] np = m_preset, nk = m_count;
      bit          nf = m_flag;
      int          nph = m_phase;
      bit          en = m_ctrl[0];
      bit          auto_rl = (m_ctrl[2:1] == 2'b01);
      if (m_phase == 0 && en) begin
         nk = m_preset; nph = 1;
      end else if (m_phase == 1) begin
         if (!en) nph = 0;
         else if (m_count > 1) nk = m_count - 1;
         else begin nk = 0; nf = 1; nph = 2; end
      end else if (m_phase == 2) begin
         nph = 0;
         if (auto_rl) nf = 0; else nc[0] = 1'b0;
      end
      if (be != 0 && off < 12) begin
         if (off < 4) begin
            nc = merge({28'h0, m_ctrl}, wd, be) & 32'hf;
            nf = 0; nph = 0;
         end else if (off < 8) begin
            np = merge(m_preset, wd, be);
         end
      end
      m_ctrl = nc; m_preset = np; m_count = nk; m_flag = nf; m_phase = nph;
   endtask

   task automatic step(logic [31:0] a, logic [3:0] be, logic [31:0] wd);
      addr = a; byteen = be; wdata = wd;
      @(posedge clk);
      if (reset) m_reset();
      else m_edge(a, be, wd);
      #1 byteen = 4'h0;
   endtask

   task automatic tick();
      step(addr, 4'h0, 32'h0);
   endtask

   task automatic rd(logic [31:0] a, string tag);
      addr = a; #1;
      check(tag, rdata, m_read(a));
   endtask

   task automatic chk_irq(string tag);
      check(tag, {31'h0, irq}, m_irq());
   endtask

   initial begin
      reset = 1'b1; addr = B; byteen = 0; wdata = 0;
      m_reset();
      step(B, 0, 0);
      step(B, 0, 0);
      reset = 1'b0;

      // reset state
      addr = B;     #1 check("rst_ctrl", rdata, 32'h0);
      addr = B + 4; #1 check("rst_preset", rdata, 32'h0);
      addr = B + 8; #1 check("rst_count", rdata, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);

      // decode: second slot ignores the first slot's addresses
      step(B + 4, 4'hf, 32'h55);
      addr = B2 + 4; #1 check("dec_b2_ignore", rdata2, 32'h0);
      check("dec_b1_oor", rdata, 32'h0);
      step(B2 + 4, 4'hf, 32'h66);
      addr = B2 + 4; #1 check("dec_b2_write", rdata2, 32'h66);
      rd(B + 4, "dec_b1_preset");
      rd(B + 12, "dec_hole");
      check("dec_hole_c", rdata, 32'h0);

      // one-shot
      step(B + 4, 4'hf, 5);
      step(B, 4'hf, 32'h9);
      for (int i = 1; i <= 5; i++) begin
         tick();
         addr = B + 8; #1 check("os_count", rdata, 32'(6 - i));
         check("os_count_m", rdata, m_count);
         chk_irq("os_irq_lo");
      end
      tick();
      check("os_irq_e6", {31'h0, irq}, 32'h1);
      tick();
      check("os_irq_e7", {31'h0, irq}, 32'h1);
      addr = B; #1 check("os_ctrl_e7", rdata, 32'h8);
      step(B, 4'hf, 32'h0);
      check("os_ack", {31'h0, irq}, 32'h0);
      chk_irq("os_ack_m");

      // auto-reload
      step(B + 4, 4'hf, 3);
      step(B, 4'hf, 32'hb);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk_irq("ar_irq");
         if (irq) pulses++;
      end
      check("ar_pulses", 32'(pulses), 32'd4);
      rd(B, "ar_ctrl");
      check("ar_en", rdata, 32'hb);
      step(B, 4'hf, 32'h0);

      // mask and byte enables
      step(B + 4, 4'hf, 2);
      step(B, 4'hf, 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("mk_irq", {31'h0, irq}, 32'h0);
      end
      rd(B + 8, "mk_count");
      check("mk_count0", rdata, 32'h0);
      step(B, 4'h1, 32'h9);
      tick(); chk_irq("mk_r1");
      tick(); check("mk_r2", {31'h0, irq}, 32'h0);
      tick(); check("mk_r3", {31'h0, irq}, 32'h1);
      step(B, 4'hf, 32'h0);
      step(B + 4, 4'hf, 32'h1122_3344);
      step(B + 4, 4'h2, 32'h0000_ab00);
      addr = B + 4; #1 check("be_preset", rdata, 32'h1122_ab44);
      rd(B + 4, "be_preset_m");

      // CTRL write colliding with the 1 -> 0 edge
      step(B + 4, 4'hf, 3);
      step(B, 4'hf, 32'hb);
      tick(); tick(); tick();
      rd(B + 8, "col_pre");
      check("col_pre1", rdata, 32'h1);
      step(B, 4'hf, 32'hb);
      check("col_irq", {31'h0, irq}, 32'h0);
      tick();
      addr = B + 8; #1 check("col_reload", rdata, 32'h3);
      tick(); chk_irq("col_i1");
      tick(); chk_irq("col_i2");
      tick(); check("col_fire", {31'h0, irq}, 32'h1);
      step(B, 4'hf, 32'h0);

      // COUNT is read-only
      step(B + 8, 4'hf, 32'hdead_beef);
      rd(B + 8, "cnt_ro");

      // reset mid-count
      step(B + 4, 4'hf, 10);
      step(B, 4'hf, 32'h9);
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      addr = B;     #1 check("mr_ctrl", rdata, 32'h0);
      addr = B + 4; #1 check("mr_preset", rdata, 32'h0);
      addr = B + 8; #1 check("mr_count", rdata, 32'h0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (irq) pulses++;
      end
      check("mr_quiet", 32'(pulses), 32'd0);

      // random bus traffic against the model
      for (int i = 0; i < 400; i++) begin
         int r;
         logic [31:0] ra;
         r = $urandom_range(0, 9);
         case (r)
            4, 5: step(B, 4'($urandom_range(1, 15)), $urandom);
            6: step(B + 4, 4'hf, $urandom_range(0, 6));
            7: step(B + 4, 4'($urandom_range(1, 15)),
                    $urandom_range(0, 6));
            8: step(B + 8, 4'($urandom_range(1, 15)), $urandom);
            9: step(($urandom_range(0, 1) != 0) ? B + 12 : 32'h8000,
                    4'hf, $urandom);
            default: tick();
         endcase
         case ($urandom_range(0, 4))
            0: ra = B;
            1: ra = B + 4;
            2: ra = B + 8;
            3: ra = B + 12;
            default: ra = $urandom;
         endcase
         rd(ra, "rnd_rdata");
         chk_irq("rnd_irq");
      end

      check("b2_irq", {31'h0, irq2}, 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
